// File: rtl/joypad_reader_pkg.sv
// Shared definitions for the NES joypad reader: FSM encoding, button indices, register address.
package joypad_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_CLK_HI = 3'd3,
        ST_CLK_LO = 3'd4,
        ST_DONE   = 3'd5
    } jp_state_t;

    localparam int BTN_A     = 0;
    localparam int BTN_B     = 1;
    localparam int BTN_SEL   = 2;
    localparam int BTN_START = 3;
    localparam int BTN_UP    = 4;
    localparam int BTN_DOWN  = 5;
    localparam int BTN_LEFT  = 6;
    localparam int BTN_RIGHT = 7;

    localparam logic [15:0] JOY1_ADDR = 16'h4016;

endpackage

// File: rtl/joypad_reader_pulse_timer.sv
// Down-counter used to time pad_latch and pad_clk phases; expired_o is high once the count reaches zero.
module pulse_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/joypad_reader.sv
// NES controller port reader: a 1->0 strobe write latches the pad, clocks in the buttons and
// snapshots them; CPU reads then shift the snapshot out one bit per read.
module joypad_reader
    import joypad_reader_pkg::*;
#(
    parameter int CLK_DIV  = 6,
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_strobe_wr,
    input  logic                cpu_wdata0,
    input  logic                cpu_rd,
    output logic                cpu_rdata,
    output logic                pad_latch,
    output logic                pad_clk,
    input  logic                pad_data,
    output logic [NUM_BITS-1:0] buttons,
    output logic                busy,
    output logic                capture_done
);

    localparam int CNT_W = $clog2(2*CLK_DIV+1);
    localparam int BIT_W = $clog2(NUM_BITS);
    localparam int PTR_W = $clog2(NUM_BITS+1);

    jp_state_t           state_q;
    logic                strobe_q;
    logic [BIT_W-1:0]    bit_q;
    logic [NUM_BITS-1:0] shift_q;
    logic [NUM_BITS-1:0] buttons_q;
    logic [PTR_W-1:0]    ptr_q;
    logic                rdata_q;
    logic                latch_q;
    logic                pclk_q;
    logic                done_q;

    logic                start;
    logic                last_bit;
    logic                tmr_load;
    logic [CNT_W-1:0]    tmr_val;
    logic                tmr_exp;

    assign start    = cpu_strobe_wr && strobe_q && !cpu_wdata0 && (state_q == ST_IDLE);
    assign last_bit = (bit_q == BIT_W'(NUM_BITS-1));

    // Timer is reloaded on entry to each timed phase; it counts the phase length minus one.
    assign tmr_load = start
                    || ((state_q == ST_SAMPLE) && !last_bit)
                    || ((state_q == ST_CLK_HI) && tmr_exp);
    assign tmr_val  = start ? CNT_W'(2*CLK_DIV-1) : CNT_W'(CLK_DIV-1);

    pulse_timer #(.W(CNT_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            strobe_q  <= 1'b0;
            bit_q     <= '0;
            shift_q   <= '0;
            buttons_q <= '0;
            ptr_q     <= PTR_W'(NUM_BITS);
            rdata_q   <= 1'b0;
            latch_q   <= 1'b0;
            pclk_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (cpu_strobe_wr) strobe_q <= cpu_wdata0;

            // Read sees pre-write state; DONE counts as busy.
            if (cpu_rd) begin
                if (state_q != ST_IDLE) begin
                    rdata_q <= 1'b0;
                end else if (ptr_q < PTR_W'(NUM_BITS)) begin
                    rdata_q <= buttons_q[ptr_q[BIT_W-1:0]];
                    ptr_q   <= ptr_q + 1'b1;
                end else begin
                    rdata_q <= 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_LATCH;
                        latch_q <= 1'b1;
                        bit_q   <= '0;
                        shift_q <= '0;
                    end
                end
                ST_LATCH: begin
                    if (tmr_exp) begin
                        state_q <= ST_SAMPLE;
                        latch_q <= 1'b0;
                    end
                end
                ST_SAMPLE: begin
                    shift_q[bit_q] <= ~pad_data;
                    bit_q          <= bit_q + 1'b1;
                    if (last_bit) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_CLK_HI;
                        pclk_q  <= 1'b1;
                    end
                end
                ST_CLK_HI: begin
                    if (tmr_exp) begin
                        state_q <= ST_CLK_LO;
                        pclk_q  <= 1'b0;
                    end
                end
                ST_CLK_LO: begin
                    if (tmr_exp) state_q <= ST_SAMPLE;
                end
                ST_DONE: begin
                    buttons_q <= shift_q;
                    ptr_q     <= '0;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cpu_rdata    = rdata_q;
    assign pad_latch    = latch_q;
    assign pad_clk      = pclk_q;
    assign buttons      = buttons_q;
    assign busy         = (state_q != ST_IDLE);
    assign capture_done = done_q;

endmodule

// File: tb/tb_joypad_reader.sv
// Directed bench for joypad_reader with a 4021-style pad model.
module tb_joypad_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpu_strobe_wr = 1'b0;
    logic       cpu_wdata0 = 1'b0;
    logic       cpu_rd = 1'b0;
    logic       cpu_rdata;
    logic       pad_latch;
    logic       pad_clk;
    logic       pad_data;
    logic [7:0] buttons;
    logic       busy;
    logic       capture_done;

    int errors = 0;
    int checks = 0;
    int cap_cnt = 0;
    int clk_rises = 0;

    logic [7:0] pressed = 8'h00;
    logic [7:0] pad_sr = 8'h00;
    logic       pclk_prev = 1'b0;

    always #5 clk = ~clk;

    joypad_reader #(.CLK_DIV(6), .NUM_BITS(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_strobe_wr (cpu_strobe_wr),
        .cpu_wdata0    (cpu_wdata0),
        .cpu_rd        (cpu_rd),
        .cpu_rdata     (cpu_rdata),
        .pad_latch     (pad_latch),
        .pad_clk       (pad_clk),
        .pad_data      (pad_data),
        .buttons       (buttons),
        .busy          (busy),
        .capture_done  (capture_done)
    );

    // Pad: parallel load while latched, shift on pad_clk rise; output is active-low.
    always @(posedge clk) begin
        pclk_prev <= pad_clk;
        if (pad_latch) pad_sr <= pressed;
        else if (pad_clk && !pclk_prev) pad_sr <= {1'b0, pad_sr[7:1]};
    end
    assign pad_data = ~pad_sr[0];

    logic mon_prev_clk = 1'b0;
    always @(negedge clk) begin
        if (capture_done) cap_cnt++;
        if (pad_clk && !mon_prev_clk) clk_rises++;
        mon_prev_clk <= pad_clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic v);
        @(negedge clk);
        cpu_strobe_wr = 1'b1;
        cpu_wdata0    = v;
        @(negedge clk);
        cpu_strobe_wr = 1'b0;
        cpu_wdata0    = 1'b0;
    endtask

    task automatic rd(output logic v);
        @(negedge clk);
        cpu_rd = 1'b1;
        @(negedge clk);
        cpu_rd = 1'b0;
        v = cpu_rdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic       r;
    logic [7:0] exp8;
    int         latch_bad, hi_cyc, rises, cap_at, cap_n, overlap, busy_seen, c0, pre_rises;
    logic       prev_pc;

    initial begin
        // Reset state
        idle(2);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_latch", pad_latch, 0);
        chk("rst_pclk", pad_clk, 0);
        chk("rst_buttons", buttons, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", capture_done, 0);
        rst_n = 1'b1;
        idle(2);

        // Scan timing and first capture with pattern A5
        pressed = 8'hA5;
        wr(1'b1);
        wr(1'b0);
        latch_bad = 0; hi_cyc = 0; rises = 0; cap_at = -1; cap_n = 0; overlap = 0;
        prev_pc = 1'b0;
        for (int k = 1; k <= 110; k++) begin
            if (pad_latch !== ((k >= 1) && (k <= 12))) latch_bad++;
            if (pad_clk) hi_cyc++;
            if (pad_clk && !prev_pc) rises++;
            if (pad_clk && pad_latch) overlap++;
            if (capture_done) begin cap_n++; cap_at = k; end
            prev_pc = pad_clk;
            @(negedge clk);
        end
        chk("latch_window", latch_bad, 0);
        chk("pclk_pulses", rises, 7);
        chk("pclk_hi_cycles", hi_cyc, 42);
        chk("latch_clk_overlap", overlap, 0);
        chk("done_count", cap_n, 1);
        chk("done_cycle", cap_at, 105);
        chk("buttons_a5", buttons, 8'hA5);
        chk("busy_after", busy, 0);

        exp8 = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            rd(r);
            chk($sformatf("read_a5_%0d", i), r, exp8[i]);
        end

        // Exhausted pointer reads return 1 with no pad activity
        pre_rises = clk_rises;
        for (int i = 0; i < 3; i++) begin
            rd(r);
            chk($sformatf("read_ovf_%0d", i), r, 1);
            chk($sformatf("ovf_latch_%0d", i), pad_latch, 0);
            chk($sformatf("ovf_busy_%0d", i), busy, 0);
        end
        chk("ovf_no_clk", clk_rises - pre_rises, 0);

        // Restart attempt and read while busy
        pressed = 8'h3C;
        c0 = cap_cnt;
        wr(1'b1);
        wr(1'b0);
        idle(30);
        wr(1'b1);
        wr(1'b0);
        rd(r);
        chk("busy_read", r, 0);
        chk("busy_flag", busy, 1);
        idle(150);
        chk("one_capture", cap_cnt - c0, 1);
        chk("buttons_3c", buttons, 8'h3C);
        exp8 = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            rd(r);
            chk($sformatf("read_3c_%0d", i), r, exp8[i]);
        end

        // Async reset during CLK_HI of bit 3
        pressed = 8'hFF;
        c0 = cap_cnt;
        pre_rises = clk_rises;
        wr(1'b1);
        wr(1'b0);
        for (int k = 0; k < 200 && (clk_rises - pre_rises) < 3; k++) @(negedge clk);
        chk("reach_bit3", clk_rises - pre_rises, 3);
        idle(1);
        chk("pre_rst_pclk", pad_clk, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pclk", pad_clk, 0);
        chk("arst_latch", pad_latch, 0);
        chk("arst_busy", busy, 0);
        chk("arst_buttons", buttons, 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        chk("arst_no_capture", cap_cnt - c0, 0);
        rd(r);
        chk("post_rst_read", r, 1);

        // Non-falling strobe writes never start a scan
        c0 = cap_cnt;
        busy_seen = 0;
        wr(1'b0);
        wr(1'b0);
        wr(1'b1);
        wr(1'b1);
        for (int k = 0; k < 30; k++) begin
            if (busy) busy_seen++;
            @(negedge clk);
        end
        chk("no_start_busy", busy_seen, 0);
        chk("no_start_capture", cap_cnt - c0, 0);
        chk("no_start_buttons", buttons, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
